forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width.
REQ-002 The block SHALL have parameter NUM_READ, default 2, meaning the number of source operand ports.
REQ-003 The block SHALL have parameter NUM_STAGES, default 2, meaning the number of forwarding stages; index 0 is the youngest (execute/memory).
REQ-004 The block SHALL have parameter LOAD_READY_STAGE, default 1, meaning the lowest stage index where WB_MEM data is valid; legal range 0..NUM_STAGES-1.
REQ-005 The block SHALL have port clock  in  1  system clock; one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 The block SHALL have port flush  in  1  squash of all instructions younger than LOAD_READY_STAGE.
REQ-008 The block SHALL have port issueValid  in  1  decode instruction accepted into execute this cycle.
REQ-009 The block SHALL have port issueDestinationRegister  in  5  rd of the issuing instruction.
REQ-010 The block SHALL have port issueWritebackType  in  writebackType_  WB type of the issuing instruction.
REQ-011 The block SHALL have port decodeValid  in  1  decode stage holds a valid instruction.
REQ-012 The block SHALL have port decodeRegister  in  NUM_READ*5  decode source registers.
REQ-013 The block SHALL have port executeRegister  in  NUM_READ*5  execute source registers.
REQ-014 The block SHALL have ports stageValid / stageDestinationRegister / stageWritebackType / stageData  in  NUM_STAGES x (1 / 5 / writebackType_ / XLEN)  per-stage result; stageData is already the final value for the stage's WB type.
REQ-015 The block SHALL have ports forwardEnable / forwardData  out  NUM_READ / NUM_READ*XLEN  per-port bypass.
REQ-016 The block SHALL have port stall  out  1  hold decode.
REQ-017 The block SHALL have port stallCycles  out  32  saturating stall-cycle count.

Function
REQ-018 Per port p, forwardEnable[p] SHALL assert combinationally when executeRegister[p]!=0 and some stage s meets all of: stageValid[s]; stageWritebackType[s]!=WB_NONE; stageDestinationRegister[s]==executeRegister[p]; and (type!=WB_MEM or s>=LOAD_READY_STAGE).
REQ-019 Among matching stages the lowest index SHALL win; forwardData[p] = stageData[winner], else 0.
REQ-020 A stage holding WB_MEM with s<LOAD_READY_STAGE that matches SHALL block all older stages for that port (enable=0, data=0), never forwarding stale older data.
REQ-021 The block SHALL keep a 32-bit register busy[] where busy[0] is hardwired to 0.
REQ-022 SET: issueValid && issueWritebackType==WB_MEM && issueDestinationRegister!=0 SHALL set busy[rd] at the next edge.
REQ-023 CLEAR: stageValid[LOAD_READY_STAGE] && stageWritebackType[LOAD_READY_STAGE]==WB_MEM SHALL clear busy[that rd] at the next edge.
REQ-024 When SET and CLEAR target the same register in the same cycle, SET SHALL win.
REQ-025 flush SHALL clear all busy bits at the next edge, and SHALL override a same-cycle SET.
REQ-026 stall SHALL equal decodeValid && some p with decodeRegister[p]!=0 && busy[decodeRegister[p]] && not (CLEAR this cycle for that register); the CLEAR bypass avoids an extra bubble.
REQ-027 stall SHALL be 0 while flush is asserted.
REQ-028 stallCycles SHALL increment by 1 every cycle stall==1 and hold at 0xFFFFFFFF.

Reset
REQ-029 reset SHALL take priority over flush, SET, CLEAR and counting.
REQ-030 At reset, busy SHALL be all 0 and stallCycles SHALL be 0; a reset mid-load discards the pending entry.
REQ-031 Combinational outputs SHALL depend only on inputs and busy, so stall=0 in the cycle after reset.

Verification
REQ-032 ALU chain: stage0 {valid, WB_ALU, rd=5, 0x11} and stage1 {valid, WB_ALU, rd=5, 0x22}, executeRegister[0]=5 -> forwardEnable[0]=1, forwardData[0]=0x11.
REQ-033 Load-use: issue WB_MEM rd=7; next cycle decodeRegister[1]=7, decodeValid=1 -> stall=1 for one cycle; load reaches stage1 -> stall=0 in that cycle, busy[7]=0 next; execute port1 then forwards the stage1 load data.
REQ-034 Young load shadow: stage0 {WB_MEM, rd=3} and stage1 {WB_ALU, rd=3, 0x55}, executeRegister[0]=3 -> forwardEnable[0]=0.
REQ-035 Simultaneous events: issue WB_MEM rd=9 in the same cycle stage1 clears rd=9 -> busy[9]=1 afterward; repeat with flush=1 -> busy[9]=0.
REQ-036 Register x0 / saturation: rd=0 load -> no busy bit and no stall; preload stallCycles to 0xFFFFFFFE and hold stall for 3 cycles -> reads 0xFFFFFFFF.
REQ-037 Reset mid-operation: busy[4]=1, stallCycles=10, then assert reset -> both 0 next cycle; decode of x4 does not stall.

Source files
------------

// File: rtl/forward_scoreboard.sv
// -----------------------------------------------------------------------------
// forward_scoreboard
//
// Purpose:
//   Operand bypass selection for the execute stage, plus a load scoreboard
//   that holds decode while a source register waits on an outstanding load.
//
//   Forwarding (combinational, per source port):
//     The youngest valid producing stage whose destination matches the
//     execute source register wins. A young load (WB_MEM in a stage whose
//     data is not ready yet) that matches blocks every older stage for that
//     port, so stale older data is never forwarded.
//
//   Scoreboard (registered):
//     busy[rd] is set when a load issues and cleared when that load reaches
//     LOAD_READY_STAGE. If a set and a clear hit the same register in one
//     cycle, the set wins. flush empties the scoreboard and overrides a set.
//     stall uses the clear of the current cycle as a bypass, so a consumer
//     is released in the same cycle its load becomes forwardable.
//
// Ports:
//   clock                    in   system clock
//   reset                    in   synchronous active-high reset
//   flush                    in   squash younger instructions, empty scoreboard
//   issueValid               in   instruction accepted into execute
//   issueDestinationRegister in   rd of the issuing instruction
//   issueWritebackType       in   WB type of the issuing instruction
//   decodeValid              in   decode stage holds a valid instruction
//   decodeRegister           in   NUM_READ x 5 decode source registers
//   executeRegister          in   NUM_READ x 5 execute source registers
//   stageValid               in   NUM_STAGES valid flags
//   stageDestinationRegister in   NUM_STAGES x 5 destination registers
//   stageWritebackType       in   NUM_STAGES WB types
//   stageData                in   NUM_STAGES x XLEN final result values
//   forwardEnable            out  NUM_READ bypass enables
//   forwardData              out  NUM_READ x XLEN bypass data (0 if disabled)
//   stall                    out  hold decode
//   stallCycles              out  saturating count of stalled cycles
// -----------------------------------------------------------------------------

package forward_scoreboard_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_CSR  = 2'd3
  } writebackType_;

endpackage

module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int NUM_READ         = 2,
  parameter int NUM_STAGES       = 2,
  parameter int LOAD_READY_STAGE = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           issueValid,
  input  logic [4:0]                     issueDestinationRegister,
  input  writebackType_                  issueWritebackType,
  input  logic                           decodeValid,
  input  logic [NUM_READ*5-1:0]          decodeRegister,
  input  logic [NUM_READ*5-1:0]          executeRegister,
  input  logic [NUM_STAGES-1:0]          stageValid,
  input  logic [NUM_STAGES*5-1:0]        stageDestinationRegister,
  input  writebackType_ [NUM_STAGES-1:0] stageWritebackType,
  input  logic [NUM_STAGES*XLEN-1:0]     stageData,
  output logic [NUM_READ-1:0]            forwardEnable,
  output logic [NUM_READ*XLEN-1:0]       forwardData,
  output logic                           stall,
  output logic [31:0]                    stallCycles
);

  // ---------------------------------------------------------------------------
  // Scoreboard events
  // ---------------------------------------------------------------------------
  logic        set_en;
  logic        clr_en;
  logic [4:0]  clr_rd;

  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  assign set_en = issueValid && (issueWritebackType == WB_MEM) &&
                  (issueDestinationRegister != 5'd0);
  assign clr_en = stageValid[LOAD_READY_STAGE] &&
                  (stageWritebackType[LOAD_READY_STAGE] == WB_MEM);
  assign clr_rd = stageDestinationRegister[LOAD_READY_STAGE*5 +: 5];

  // Order of overrides: clear, then set (set wins), then flush (wins over all).
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (set_en) begin
      busy_d[issueDestinationRegister] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Decode hazard detection
  // ---------------------------------------------------------------------------
  logic [NUM_READ-1:0] dec_hazard;

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_dec
    logic [4:0] dec_rs;
    assign dec_rs = decodeRegister[gi*5 +: 5];
    // A load clearing this register right now is forwardable this cycle,
    // so it does not need to hold decode.
    assign dec_hazard[gi] = (dec_rs != 5'd0) && busy_q[dec_rs] &&
                            !(clr_en && (clr_rd == dec_rs));
  end

  assign stall = decodeValid && !flush && (|dec_hazard);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      busy_q         <= busy_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stallCycles = stall_cycles_q;

  // ---------------------------------------------------------------------------
  // Forwarding network
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_fwd
    logic [4:0]            exe_rs;
    logic [NUM_STAGES-1:0] hit;
    logic [NUM_STAGES-1:0] usable;
    logic                  fwd_en;
    logic [XLEN-1:0]       fwd_data;

    assign exe_rs = executeRegister[gi*5 +: 5];

    for (genvar gs = 0; gs < NUM_STAGES; gs++) begin : g_stage
      localparam bit YOUNG = (gs < LOAD_READY_STAGE);
      assign hit[gs] = stageValid[gs] &&
                       (stageWritebackType[gs] != WB_NONE) &&
                       (stageDestinationRegister[gs*5 +: 5] == exe_rs);
      // A load still ahead of its ready stage matches but carries no data.
      assign usable[gs] = !(YOUNG && (stageWritebackType[gs] == WB_MEM));
    end

    // Walk oldest to youngest so the youngest match is the last to write;
    // an unusable young match thereby also masks every older stage.
    always_comb begin
      fwd_en   = 1'b0;
      fwd_data = '0;
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
        if (hit[s]) begin
          fwd_en   = usable[s];
          fwd_data = usable[s] ? stageData[s*XLEN +: XLEN] : '0;
        end
      end
      if (exe_rs == 5'd0) begin
        fwd_en   = 1'b0;
        fwd_data = '0;
      end
    end

    assign forwardEnable[gi]            = fwd_en;
    assign forwardData[gi*XLEN +: XLEN] = fwd_data;
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_forward_scoreboard
//
// Directed scenarios (ALU chain, load-use, young load shadow, simultaneous
// set/clear/flush, x0 and counter saturation, reset mid-load) followed by a
// randomized phase. A reference model written from the behavioural rules
// (first matching stage search, a bit array scoreboard, a plain counter)
// predicts every output each cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_forward_scoreboard;
  import forward_scoreboard_pkg::*;

  localparam int XL = 32;
  localparam int NR = 2;
  localparam int NS = 2;
  localparam int LR = 1;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   issueValid;
  logic [4:0]             issueDestinationRegister;
  writebackType_          issueWritebackType;
  logic                   decodeValid;
  logic [NR*5-1:0]        decodeRegister;
  logic [NR*5-1:0]        executeRegister;
  logic [NS-1:0]          stageValid;
  logic [NS*5-1:0]        stageDestinationRegister;
  writebackType_ [NS-1:0] stageWritebackType;
  logic [NS*XL-1:0]       stageData;
  logic [NR-1:0]          forwardEnable;
  logic [NR*XL-1:0]       forwardData;
  logic                   stall;
  logic [31:0]            stallCycles;

  forward_scoreboard #(
    .XLEN(XL), .NUM_READ(NR), .NUM_STAGES(NS), .LOAD_READY_STAGE(LR)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issueValid(issueValid),
    .issueDestinationRegister(issueDestinationRegister),
    .issueWritebackType(issueWritebackType),
    .decodeValid(decodeValid), .decodeRegister(decodeRegister),
    .executeRegister(executeRegister),
    .stageValid(stageValid),
    .stageDestinationRegister(stageDestinationRegister),
    .stageWritebackType(stageWritebackType),
    .stageData(stageData),
    .forwardEnable(forwardEnable), .forwardData(forwardData),
    .stall(stall), .stallCycles(stallCycles)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          busy_m [32];
  logic [31:0] cnt_m;
  logic        exp_fe    [NR];
  logic [31:0] exp_fd    [NR];
  logic        exp_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    logic [4:0] rs;
    bit         found;
    bit         clr;
    logic [4:0] crd;
    for (int p = 0; p < NR; p++) begin
      rs        = executeRegister[p*5 +: 5];
      exp_fe[p] = 1'b0;
      exp_fd[p] = '0;
      found     = 0;
      if (rs != 0) begin
        for (int s = 0; s < NS; s++) begin
          if (!found && stageValid[s] && stageWritebackType[s] != WB_NONE &&
              stageDestinationRegister[s*5 +: 5] == rs) begin
            found = 1;
            if (!(stageWritebackType[s] == WB_MEM && s < LR)) begin
              exp_fe[p] = 1'b1;
              exp_fd[p] = stageData[s*XL +: XL];
            end
          end
        end
      end
    end
    clr = stageValid[LR] && stageWritebackType[LR] == WB_MEM;
    crd = stageDestinationRegister[LR*5 +: 5];
    exp_stall = 1'b0;
    if (decodeValid && !flush) begin
      for (int p = 0; p < NR; p++) begin
        rs = decodeRegister[p*5 +: 5];
        if (rs != 0 && busy_m[rs] && !(clr && crd == rs)) exp_stall = 1'b1;
      end
    end
  endtask

  task automatic model_seq();
    if (reset) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      cnt_m = 0;
    end else begin
      if (exp_stall && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
      if (flush) begin
        foreach (busy_m[i]) busy_m[i] = 0;
      end else begin
        if (stageValid[LR] && stageWritebackType[LR] == WB_MEM)
          busy_m[stageDestinationRegister[LR*5 +: 5]] = 0;
        if (issueValid && issueWritebackType == WB_MEM)
          busy_m[issueDestinationRegister] = 1;
      end
      busy_m[0] = 0;
    end
  endtask

  // Called shortly after a rising edge with the cycle's inputs already driven.
  task automatic cycle(input string tag);
    #2;
    model_comb();
    for (int p = 0; p < NR; p++) begin
      chk({tag, "_fe"}, 32'(forwardEnable[p]), 32'(exp_fe[p]));
      chk({tag, "_fd"}, forwardData[p*XL +: XL], exp_fd[p]);
    end
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    $display("txn %s t=%0t fe=%b stall=%0b", tag, $time, forwardEnable, stall);
    @(posedge clock);
    model_seq();
    #1;
    chk({tag, "_cnt"}, stallCycles, cnt_m);
  endtask

  task automatic set_stage(input int s, input logic v, input writebackType_ t,
                           input logic [4:0] rd, input logic [31:0] d);
    stageValid[s]                   = v;
    stageWritebackType[s]           = t;
    stageDestinationRegister[s*5 +: 5] = rd;
    stageData[s*XL +: XL]           = d;
  endtask

  task automatic idle();
    flush                    = 1'b0;
    issueValid               = 1'b0;
    issueDestinationRegister = '0;
    issueWritebackType       = WB_NONE;
    decodeValid              = 1'b0;
    decodeRegister           = '0;
    executeRegister          = '0;
    for (int s = 0; s < NS; s++) set_stage(s, 1'b0, WB_NONE, 5'd0, 32'd0);
  endtask

  task automatic issue_load(input logic [4:0] rd);
    issueValid               = 1'b1;
    issueWritebackType       = WB_MEM;
    issueDestinationRegister = rd;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    foreach (busy_m[i]) busy_m[i] = 0;
    cnt_m = 0;
    @(posedge clock);
    #1;

    // Reset state
    cycle("reset");
    reset = 1'b0;
    decodeValid = 1'b1;
    decodeRegister = {5'd3, 5'd1};
    #1;
    chk("post_reset_stall", 32'(stall), 32'd0);
    cycle("post_reset");

    // ALU chain: youngest wins
    idle();
    set_stage(0, 1'b1, WB_ALU, 5'd5, 32'h11);
    set_stage(1, 1'b1, WB_ALU, 5'd5, 32'h22);
    executeRegister = {5'd0, 5'd5};
    #1;
    chk("alu_chain_en", 32'(forwardEnable[0]), 32'd1);
    chk("alu_chain_data", forwardData[31:0], 32'h11);
    cycle("alu_chain");

    // Load-use
    idle();
    issue_load(5'd7);
    cycle("lu_issue");
    idle();
    set_stage(0, 1'b1, WB_MEM, 5'd7, 32'h0);
    decodeValid = 1'b1;
    decodeRegister = {5'd7, 5'd0};
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    cycle("lu_wait");
    set_stage(0, 1'b0, WB_NONE, 5'd0, 32'h0);
    set_stage(1, 1'b1, WB_MEM, 5'd7, 32'hABCD);
    executeRegister = {5'd7, 5'd0};
    #1;
    chk("lu_release", 32'(stall), 32'd0);
    chk("lu_fwd_en", 32'(forwardEnable[1]), 32'd1);
    chk("lu_fwd_data", forwardData[63:32], 32'hABCD);
    cycle("lu_ready");
    set_stage(1, 1'b0, WB_NONE, 5'd0, 32'h0);
    executeRegister = '0;
    #1;
    chk("lu_cleared", 32'(stall), 32'd0);
    cycle("lu_after");

    // Young load shadows older ALU result
    idle();
    set_stage(0, 1'b1, WB_MEM, 5'd3, 32'h99);
    set_stage(1, 1'b1, WB_ALU, 5'd3, 32'h55);
    executeRegister = {5'd0, 5'd3};
    #1;
    chk("shadow_en", 32'(forwardEnable[0]), 32'd0);
    chk("shadow_data", forwardData[31:0], 32'd0);
    cycle("shadow");

    // Simultaneous set and clear on x9: set wins
    idle();
    issue_load(5'd9);
    set_stage(1, 1'b1, WB_MEM, 5'd9, 32'h9);
    cycle("setclr");
    idle();
    decodeValid = 1'b1;
    decodeRegister = {5'd0, 5'd9};
    #1;
    chk("setclr_busy", 32'(stall), 32'd1);
    cycle("setclr_chk");
    // Same with flush: flush wins, stall suppressed during flush
    issue_load(5'd9);
    set_stage(1, 1'b1, WB_MEM, 5'd9, 32'h9);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    cycle("flush");
    idle();
    decodeValid = 1'b1;
    decodeRegister = {5'd0, 5'd9};
    #1;
    chk("flush_busy", 32'(stall), 32'd0);
    cycle("flush_chk");

    // Load to x0 never marks busy
    idle();
    issue_load(5'd0);
    cycle("x0_issue");
    idle();
    decodeValid = 1'b1;
    decodeRegister = {5'd0, 5'd0};
    #1;
    chk("x0_stall", 32'(stall), 32'd0);
    cycle("x0_chk");

    // Counter saturation
    idle();
    issue_load(5'd12);
    cycle("sat_issue");
    idle();
    decodeValid = 1'b1;
    decodeRegister = {5'd12, 5'd0};
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    cnt_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cycle("sat");
    chk("sat_value", stallCycles, 32'hFFFF_FFFF);

    // Reset mid-operation
    idle();
    reset = 1'b1;
    cycle("pre_rst");
    reset = 1'b0;
    issue_load(5'd4);
    cycle("mid_issue");
    idle();
    decodeValid = 1'b1;
    decodeRegister = {5'd0, 5'd4};
    for (int i = 0; i < 10; i++) cycle("mid_stall");
    chk("mid_count10", stallCycles, 32'd10);
    reset = 1'b1;
    cycle("mid_reset");
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    cycle("mid_after");
    chk("mid_rst_count", stallCycles, 32'd0);

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      reset                    = ($urandom_range(0, 63) == 0);
      flush                    = ($urandom_range(0, 23) == 0);
      issueValid               = $urandom_range(0, 1);
      issueDestinationRegister = 5'($urandom_range(0, 7));
      issueWritebackType       = ($urandom_range(0, 1) == 0) ? WB_MEM
                                 : writebackType_'($urandom_range(0, 3));
      decodeValid              = $urandom_range(0, 1);
      for (int p = 0; p < NR; p++) begin
        decodeRegister[p*5 +: 5]  = 5'($urandom_range(0, 7));
        executeRegister[p*5 +: 5] = 5'($urandom_range(0, 7));
      end
      for (int s = 0; s < NS; s++)
        set_stage(s, 1'($urandom_range(0, 1)), writebackType_'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), $urandom);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
